multicast_controller: RTL and testbench



---
 rtl/multicast_controller.sv | 127 ++++++++++++
 tb/tb_multicast_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicast_controller.sv
// Per-PE multicast controller: filters tagged bus words by a programmable ID (or the
// all-ones broadcast tag), buffers matches in a small FIFO and strobes them into one PE load port.
module multicast_controller #(
    parameter int BITWIDTH        = 16,
    parameter int ID_WIDTH        = 5,
    parameter int FIFO_ADDR_WIDTH = 2,
    parameter int FIFO_DEPTH      = 2**FIFO_ADDR_WIDTH,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       config_enable,
    input  logic [ID_WIDTH-1:0]        config_id,
    input  logic                       bus_valid,
    input  logic [ID_WIDTH-1:0]        bus_tag,
    input  logic signed [BITWIDTH-1:0] bus_data,
    output logic                       bus_ready,
    input  logic                       pe_ready,
    output logic                       pe_enable,
    output logic signed [BITWIDTH-1:0] pe_data,
    output logic [COUNT_WIDTH-1:0]     delivered_count
);

    typedef enum logic {
        UNCONFIGURED,
        RUN
    } state_t;

    localparam logic [FIFO_ADDR_WIDTH:0] FULL_LEVEL = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);

    state_t                       state;
    state_t                       state_next;
    logic [ID_WIDTH-1:0]          my_id;
    logic [FIFO_ADDR_WIDTH-1:0]   rd_ptr;
    logic [FIFO_ADDR_WIDTH-1:0]   wr_ptr;
    logic [FIFO_ADDR_WIDTH:0]     occupancy;
    logic signed [BITWIDTH-1:0]   mem [FIFO_DEPTH];

    logic configured;
    logic fifo_full;
    logic fifo_empty;
    logic tag_match;
    logic push;
    logic pop;

    assign configured = (state == RUN);
    assign fifo_full  = (occupancy == FULL_LEVEL);
    assign fifo_empty = (occupancy == '0);
    assign tag_match  = (bus_tag == my_id) || (&bus_tag);
    assign bus_ready  = configured && !fifo_full;

    // Configuration wins over both sides of the FIFO in the same cycle.
    assign push = bus_valid && bus_ready && tag_match && !config_enable;
    assign pop  = !fifo_empty && pe_ready && !config_enable;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= UNCONFIGURED;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            UNCONFIGURED: if (config_enable) state_next = RUN;
            RUN:          state_next = RUN;
            default:      state_next = UNCONFIGURED;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            my_id <= '0;
        end else if (config_enable) begin
            my_id <= config_id;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else if (config_enable) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // NOTE: storage is not reset; pointer/occupancy reset alone makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_data;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pe_enable       <= 1'b0;
            pe_data         <= '0;
            delivered_count <= '0;
        end else if (config_enable) begin
            pe_enable       <= 1'b0;
            delivered_count <= '0;
        end else if (pop) begin
            pe_enable       <= 1'b1;
            pe_data         <= mem[rd_ptr];
            delivered_count <= delivered_count + 1'b1;
        end else begin
            pe_enable       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multicast_controller.sv
// Scoreboard bench for multicast_controller: stimulus queues expected PE words,
// an independent negedge monitor pops and compares on every pe_enable.
module tb_multicast_controller;

    localparam int BW = 16;
    localparam int IW = 5;
    localparam int CW = 8;

    logic                 clk = 1'b0;
    logic                 rstb = 1'b0;
    logic                 config_enable = 1'b0;
    logic [IW-1:0]        config_id = '0;
    logic                 bus_valid = 1'b0;
    logic [IW-1:0]        bus_tag = '0;
    logic signed [BW-1:0] bus_data = '0;
    logic                 bus_ready;
    logic                 pe_ready = 1'b0;
    logic                 pe_enable;
    logic signed [BW-1:0] pe_data;
    logic [CW-1:0]        delivered_count;

    int compared   = 0;
    int mismatched = 0;
    logic signed [BW-1:0] exp_q[$];

    multicast_controller #(
        .BITWIDTH(BW), .ID_WIDTH(IW), .FIFO_ADDR_WIDTH(2), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rstb(rstb),
        .config_enable(config_enable), .config_id(config_id),
        .bus_valid(bus_valid), .bus_tag(bus_tag), .bus_data(bus_data),
        .bus_ready(bus_ready),
        .pe_ready(pe_ready), .pe_enable(pe_enable), .pe_data(pe_data),
        .delivered_count(delivered_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every delivered word must be the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rstb && pe_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_delivery: got pe_data=%0d, expected no delivery (t=%0t)",
                         pe_data, $time);
            end else begin
                check("pe_data_order", pe_data, exp_q.pop_front());
            end
        end
    end

    task automatic wait_accept(input bit match, input logic signed [BW-1:0] data);
        int n = 0;
        while (bus_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got bus_ready=%b, expected 1 within 50 cycles", bus_ready);
        end else if (match) begin
            exp_q.push_back(data);
        end
    endtask

    task automatic send_word(input logic [IW-1:0] tag, input logic signed [BW-1:0] data,
                             input bit match);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_tag   = tag;
        bus_data  = data;
        wait_accept(match, data);
    endtask

    task automatic idle();
        @(negedge clk);
        bus_valid = 1'b0;
    endtask

    task automatic configure(input logic [IW-1:0] id);
        @(negedge clk);
        config_enable = 1'b1;
        config_id     = id;
        @(negedge clk);
        config_enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, then an unconfigured controller must ignore the bus.
        #2;
        check("rst_bus_ready", bus_ready, 0);
        check("rst_pe_enable", pe_enable, 0);
        check("rst_pe_data", pe_data, 0);
        check("rst_count", delivered_count, 0);
        @(negedge clk);
        rstb      = 1'b1;
        bus_valid = 1'b1;
        bus_tag   = 5'd31;
        bus_data  = 16'sd99;
        repeat (3) begin
            @(negedge clk);
            check("unconfigured_bus_ready", bus_ready, 0);
        end
        bus_valid = 1'b0;

        // ID 3: tags 3, 5, 31 -> 10 at edge 2, -20 dropped, 7 at edge 4.
        configure(5'd3);
        pe_ready = 1'b1;
        check("configured_bus_ready", bus_ready, 1);
        bus_valid = 1'b1; bus_tag = 5'd3; bus_data = 16'sd10;
        exp_q.push_back(16'sd10);
        @(negedge clk);
        check("latency_not_early", pe_enable, 0);
        bus_tag = 5'd5; bus_data = -16'sd20;
        @(negedge clk);
        check("latency_enable", pe_enable, 1);
        check("latency_data", pe_data, 10);
        bus_tag = 5'd31; bus_data = 16'sd7;
        exp_q.push_back(16'sd7);
        @(negedge clk);
        bus_valid = 1'b0;
        check("dropped_tag_gap", pe_enable, 0);
        @(negedge clk);
        check("broadcast_enable", pe_enable, 1);
        check("broadcast_data", pe_data, 7);
        @(negedge clk);
        check("count_after_filter", delivered_count, 2);

        // Stall: four words fill the FIFO, the fifth is back-pressured.
        pe_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_word(5'd3, BW'(i), 1'b1);
        @(negedge clk);
        bus_valid = 1'b1; bus_tag = 5'd3; bus_data = 16'sd5;
        check("full_bus_ready", bus_ready, 0);
        repeat (2) begin
            @(negedge clk);
            check("stall_hold_ready", bus_ready, 0);
        end
        pe_ready = 1'b1;
        fork
            begin
                wait_accept(1'b1, 16'sd5);
                send_word(5'd3, 16'sd6, 1'b1);
                idle();
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    check("drain_back_to_back", pe_enable, 1);
                end
                @(negedge clk);
                check("drain_done", pe_enable, 0);
            end
        join
        check("count_after_drain", delivered_count, 8);

        // Sustained broadcast stream across several pointer wraps.
        fork
            begin
                for (int i = 0; i < 10; i++) send_word(5'd31, BW'(100 + i), 1'b1);
                idle();
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (pe_enable !== 1'b1 && n < 20);
                check("stream_start", pe_enable, 1);
                repeat (9) begin
                    @(negedge clk);
                    check("stream_enable_and_ready", {pe_enable, bus_ready}, 3);
                end
            end
        join
        check("count_after_stream", delivered_count, 18);

        // Reconfigure to ID 7 with two words buffered and a bus word in flight.
        @(negedge clk);
        pe_ready = 1'b0;
        send_word(5'd3, 16'sd50, 1'b1);
        send_word(5'd3, 16'sd51, 1'b1);
        @(negedge clk);
        config_enable = 1'b1; config_id = 5'd7;
        bus_valid = 1'b1; bus_tag = 5'd7; bus_data = 16'sd60;
        pe_ready = 1'b1;
        @(posedge clk);
        #1 exp_q.delete();
        @(negedge clk);
        config_enable = 1'b0;
        bus_valid     = 1'b0;
        check("config_no_enable", pe_enable, 0);
        check("config_count_clear", delivered_count, 0);
        check("config_flush_ready", bus_ready, 1);
        send_word(5'd7, 16'sd70, 1'b1);
        send_word(5'd3, 16'sd71, 1'b0);
        send_word(5'd31, 16'sd72, 1'b1);
        send_word(5'd9, 16'sd73, 1'b0);
        idle();
        repeat (4) @(negedge clk);
        check("count_after_reconfig", delivered_count, 2);
        check("reconfig_drained", exp_q.size(), 0);

        // Asynchronous reset with three words buffered.
        @(negedge clk);
        pe_ready = 1'b0;
        send_word(5'd7, 16'sd80, 1'b1);
        send_word(5'd7, 16'sd81, 1'b1);
        send_word(5'd7, 16'sd82, 1'b1);
        idle();
        #2 rstb = 1'b0;
        #1;
        check("async_rst_bus_ready", bus_ready, 0);
        check("async_rst_pe_enable", pe_enable, 0);
        check("async_rst_pe_data", pe_data, 0);
        check("async_rst_count", delivered_count, 0);
        exp_q.delete();
        @(negedge clk);
        pe_ready = 1'b1;
        rstb     = 1'b1;
        bus_valid = 1'b1; bus_tag = 5'd31; bus_data = 16'sd1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_bus_ready", bus_ready, 0);
        end
        bus_valid = 1'b0;
        check("post_rst_count", delivered_count, 0);
        configure(5'd7);
        send_word(5'd7, 16'sd90, 1'b1);
        idle();
        repeat (4) @(negedge clk);
        check("count_after_rst_config", delivered_count, 1);

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
